// File: rtl/bcd_timer_pkg.sv
// bcd_timer_pkg: run/stop state encoding, BCD digit limit and load clamp helper
package bcd_timer_pkg;
   typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} state_t;
   localparam logic [3:0] BCD_MAX = 4'd9;
   function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
      return (v > BCD_MAX) ? BCD_MAX : v;
   endfunction
endpackage

// File: rtl/bcd_digit_timer_digit.sv
// bcd_digit: one BCD digit with increment/decrement, load, clear and ripple carry/borrow
module bcd_digit
   import bcd_timer_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_inc,
   input  logic       i_dec,
   input  logic       i_load,
   input  logic       i_clear,
   input  logic [3:0] i_d,
   output logic [3:0] o_q,
   output logic       o_carry,
   output logic       o_borrow
);
   logic [3:0] r_q;
   always_ff @(posedge i_clk)
      if (i_reset || i_clear) r_q <= '0;
      else if (i_load) r_q <= bcd_clamp(i_d);
      else if (i_inc) r_q <= (r_q == BCD_MAX) ? 4'd0 : r_q + 4'd1;
      else if (i_dec) r_q <= (r_q == 4'd0) ? BCD_MAX : r_q - 4'd1;
   assign o_q      = r_q;
   assign o_carry  = i_inc && (r_q == BCD_MAX);
   assign o_borrow = i_dec && (r_q == 4'd0);
endmodule

// File: rtl/bcd_digit_timer.sv
// bcd_digit_timer: prescaled multi-digit BCD counter with run/stop FSM, clear and load
// Optional down counting with expiry is enabled by defining BCD_TIMER_DOWN_EN.
module bcd_digit_timer
   import bcd_timer_pkg::*;
#(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 1,
   parameter int DIGITS  = 4
)(
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic                i_clear,
   input  logic                i_load,
   input  logic [4*DIGITS-1:0] i_load_value,
`ifdef BCD_TIMER_DOWN_EN
   input  logic                i_down,
`endif
   output logic [4*DIGITS-1:0] o_digits,
   output logic                o_running,
   output logic                o_tick,
   output logic                o_wrap
);
   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
   state_t r_state;
   logic [PW-1:0] r_presc;
   logic r_tick, r_wrap;
   logic w_down, w_step, w_expire, w_wrap;
   logic [DIGITS-1:0] w_inc, w_dec, w_carry, w_borrow;
`ifdef BCD_TIMER_DOWN_EN
   assign w_down = i_down;
`else
   assign w_down = 1'b0;
`endif
   assign w_step = (r_state == ST_RUNNING) && (r_presc == PRE_LAST) && !i_clear && !i_load;
   // a borrow out of the top digit means the value was all zero: clear instead of wrapping to 9s
   assign w_expire = w_borrow[DIGITS-1];
   assign w_wrap   = w_carry[DIGITS-1] | w_expire;
   genvar i;
   generate
      for (i = 0; i < DIGITS; i++) begin : g_dig
         if (i == 0) begin : g_lsd
            assign w_inc[i] = w_step && !w_down;
            assign w_dec[i] = w_step && w_down;
         end else begin : g_chain
            assign w_inc[i] = w_carry[i-1];
            assign w_dec[i] = w_borrow[i-1];
         end
         bcd_digit u_digit (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_inc   (w_inc[i]),
            .i_dec   (w_dec[i]),
            .i_load  (i_load),
            .i_clear (i_clear | w_expire),
            .i_d     (i_load_value[4*i +: 4]),
            .o_q     (o_digits[4*i +: 4]),
            .o_carry (w_carry[i]),
            .o_borrow(w_borrow[i])
         );
      end
   endgenerate
   always_ff @(posedge i_clk)
      if (i_reset || i_clear || i_load) r_presc <= '0;
      else if (r_state == ST_RUNNING) r_presc <= (r_presc == PRE_LAST) ? '0 : r_presc + 1'b1;
   always_ff @(posedge i_clk)
      if (i_reset) r_state <= ST_STOPPED;
      else if (i_stop || w_expire) r_state <= ST_STOPPED;
      else if (i_start) r_state <= ST_RUNNING;
   always_ff @(posedge i_clk)
      if (i_reset) begin
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
      end else begin
         r_tick <= w_step;
         r_wrap <= w_wrap;
      end
   assign o_running = (r_state == ST_RUNNING);
   assign o_tick    = r_tick;
   assign o_wrap    = r_wrap;
endmodule

// File: tb/tb_bcd_digit_timer.sv
// tb_bcd_digit_timer: table vectors plus step scoreboard for bcd_digit_timer (DIV = 4)
module tb_bcd_digit_timer;
   typedef struct {
      logic [15:0] d;
      logic        w;
   } exp_t;
   typedef struct {
      string       name;
      logic        st, sp, cl, ld;
      logic [15:0] lv;
      logic [15:0] d;
      logic        run;
   } vec_t;
   logic clk = 1'b0;
   logic i_reset = 1'b0, i_start = 1'b0, i_stop = 1'b0, i_clear = 1'b0, i_load = 1'b0;
   logic [15:0] i_load_value = '0;
   logic i_down = 1'b0;
   logic [15:0] o_digits;
   logic o_running, o_tick, o_wrap;
   int n_tests = 0, n_fail = 0;
   exp_t sb[$];
   vec_t vt[10];
   bcd_digit_timer #(.CLK_HZ(4), .TICK_HZ(1), .DIGITS(4)) dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_start     (i_start),
      .i_stop      (i_stop),
      .i_clear     (i_clear),
      .i_load      (i_load),
      .i_load_value(i_load_value),
`ifdef BCD_TIMER_DOWN_EN
      .i_down      (i_down),
`endif
      .o_digits    (o_digits),
      .o_running   (o_running),
      .o_tick      (o_tick),
      .o_wrap      (o_wrap)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic pulse(input logic st, input logic sp, input logic cl, input logic ld, input logic [15:0] lv);
      i_start = st; i_stop = sp; i_clear = cl; i_load = ld; i_load_value = lv;
      step();
      i_start = 1'b0; i_stop = 1'b0; i_clear = 1'b0; i_load = 1'b0;
   endtask
   task automatic expect_step(input string nm, input int gap);
      int n;
      exp_t e;
      n = 0;
      do begin
         step();
         n++;
      end while (!o_tick && n < gap + 4);
      chk({nm, " gap"}, 32'(n), 32'(gap));
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: step seen with empty scoreboard", nm);
      end else begin
         e = sb.pop_front();
         chk({nm, " digits"}, 32'(o_digits), 32'(e.d));
         chk({nm, " wrap"}, 32'(o_wrap), 32'(e.w));
      end
   endtask
   function automatic vec_t mk(string nm, logic st, logic sp, logic cl, logic ld, logic [15:0] lv,
                               logic [15:0] d, logic run);
      vec_t v;
      v.name = nm; v.st = st; v.sp = sp; v.cl = cl; v.ld = ld; v.lv = lv; v.d = d; v.run = run;
      return v;
   endfunction
   initial begin
      exp_t e;
      vt[0] = mk("clr",        0, 0, 1, 0, 16'h0000, 16'h0000, 0);
      vt[1] = mk("ld_1234",    0, 0, 0, 1, 16'h1234, 16'h1234, 0);
      vt[2] = mk("clr_ld_pri", 0, 0, 1, 1, 16'hA5F3, 16'h0000, 0);
      vt[3] = mk("ld_clamp",   0, 0, 0, 1, 16'hA5F3, 16'h9593, 0);
      vt[4] = mk("ld_ffff",    0, 0, 0, 1, 16'hFFFF, 16'h9999, 0);
      vt[5] = mk("start_stop", 1, 1, 0, 0, 16'h0000, 16'h9999, 0);
      vt[6] = mk("clr2",       0, 0, 1, 0, 16'h0000, 16'h0000, 0);
      vt[7] = mk("ld_start",   1, 0, 0, 1, 16'h0909, 16'h0909, 1);
      vt[8] = mk("stop",       0, 1, 0, 0, 16'h0000, 16'h0909, 0);
      vt[9] = mk("clr3",       0, 0, 1, 0, 16'h0000, 16'h0000, 0);
      i_reset = 1'b1;
      step();
      step();
      chk("rst digits", 32'(o_digits), 32'h0);
      chk("rst running", 32'(o_running), 32'h0);
      chk("rst tick", 32'(o_tick), 32'h0);
      chk("rst wrap", 32'(o_wrap), 32'h0);
      i_reset = 1'b0;
      pulse(1, 0, 0, 0, 16'h0);
      chk("start running", 32'(o_running), 32'h1);
      for (int v = 1; v <= 12; v++) sb.push_back('{16'((v / 10) * 16 + v % 10), 1'b0});
      for (int s = 0; s < 12; s++) expect_step("count", 4);
      chk("count final", 32'(o_digits), 32'h0012);
      pulse(0, 1, 0, 0, 16'h0);
      for (int i = 0; i < 10; i++) begin
         pulse(vt[i].st, vt[i].sp, vt[i].cl, vt[i].ld, vt[i].lv);
         sb.push_back('{vt[i].d, vt[i].run});
         e = sb.pop_front();
         chk({vt[i].name, " digits"}, 32'(o_digits), 32'(e.d));
         chk({vt[i].name, " running"}, 32'(o_running), 32'(e.w));
         chk({vt[i].name, " tick"}, 32'(o_tick), 32'h0);
      end
      pulse(0, 0, 0, 1, 16'h9998);
      pulse(1, 0, 0, 0, 16'h0);
      sb.push_back('{16'h9999, 1'b0});
      sb.push_back('{16'h0000, 1'b1});
      expect_step("roll1", 4);
      expect_step("roll2", 4);
      chk("roll tick", 32'(o_tick), 32'h1);
      step();
      chk("roll tick end", 32'(o_tick), 32'h0);
      chk("roll wrap end", 32'(o_wrap), 32'h0);
      chk("roll running", 32'(o_running), 32'h1);
      pulse(0, 1, 0, 0, 16'h0);
      pulse(0, 0, 1, 0, 16'h0);
      pulse(1, 0, 0, 0, 16'h0);
      step();
      pulse(0, 1, 0, 0, 16'h0);
      chk("hold running", 32'(o_running), 32'h0);
      for (int c = 0; c < 5; c++) begin
         step();
         chk("hold tick", 32'(o_tick), 32'h0);
      end
      chk("hold digits", 32'(o_digits), 32'h0);
      pulse(1, 0, 0, 0, 16'h0);
      sb.push_back('{16'h0001, 1'b0});
      expect_step("resume", 2);
      pulse(0, 1, 0, 0, 16'h0);
      pulse(0, 0, 1, 0, 16'h0);
      pulse(0, 0, 0, 1, 16'h0042);
      pulse(1, 0, 0, 0, 16'h0);
      step();
      step();
      i_reset = 1'b1;
      step();
      i_reset = 1'b0;
      chk("mid rst digits", 32'(o_digits), 32'h0);
      chk("mid rst running", 32'(o_running), 32'h0);
      chk("mid rst tick", 32'(o_tick), 32'h0);
      chk("mid rst wrap", 32'(o_wrap), 32'h0);
      for (int c = 0; c < 6; c++) begin
         step();
         chk("post rst tick", 32'(o_tick), 32'h0);
      end
      chk("post rst digits", 32'(o_digits), 32'h0);
`ifdef BCD_TIMER_DOWN_EN
      pulse(0, 0, 0, 1, 16'h0100);
      i_down = 1'b1;
      pulse(1, 0, 0, 0, 16'h0);
      sb.push_back('{16'h0099, 1'b0});
      sb.push_back('{16'h0098, 1'b0});
      expect_step("down1", 4);
      expect_step("down2", 4);
      pulse(0, 1, 0, 0, 16'h0);
      pulse(0, 0, 0, 1, 16'h0001);
      pulse(1, 0, 0, 0, 16'h0);
      sb.push_back('{16'h0000, 1'b0});
      sb.push_back('{16'h0000, 1'b1});
      expect_step("exp1", 4);
      chk("exp1 running", 32'(o_running), 32'h1);
      expect_step("exp2", 4);
      chk("exp2 running", 32'(o_running), 32'h0);
      step();
      chk("exp tick end", 32'(o_tick), 32'h0);
      chk("exp digits", 32'(o_digits), 32'h0);
      i_down = 1'b0;
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/bcd_digit_timer.md
# bcd_digit_timer

Multi-digit BCD up/down counter with a built-in prescaler that generates the 4-bit digit values driving the board's seven-segment decoders. Each `DIGITS` nibble connects directly to one `hex_display` instance (`c` input). It serves as the game's score and elapsed-time/countdown source. The counter is gated by a run/stop state machine and accepts synchronous clear and parallel load.

## Interface
- `CLK_HZ`, 50000000, input clock frequency.
- `TICK_HZ`, 1, count rate. Prescaler divisor `DIV = CLK_HZ/TICK_HZ`; the divisor must be ≥ 2.
- `DIGITS`, 4, number of BCD digits. Valid range is 1–8.
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to enter RUNNING.
- `stop`  in  1  one-cycle request to enter STOPPED.
- `clear`  in  1  sets all digits to 0 and restarts the prescaler.
- `load`  in  1  parallel load of `load_value`.
- `load_value`  in  4*DIGITS  BCD digits; digit 0 occupies `[3:0]`.
- `down`  in  1  count direction: 1 = decrement. This port is present only when `BCD_TIMER_DOWN_EN` is defined.
- `digits`  out  4*DIGITS  registered BCD value sent to `hex_display` instances.
- `running`  out  1  high while in the RUNNING state.
- `tick`  out  1  one-cycle pulse on each count step.
- `wrap`  out  1  one-cycle pulse on rollover (up) or on expiry (down).

## Operation
- States are STOPPED and RUNNING.
  - STOPPED → RUNNING on `start`.
  - RUNNING → STOPPED on `stop`.
  - If `start` and `stop` are asserted together, `stop` wins.
  - In the down-count configuration, expiry also forces RUNNING → STOPPED.
- The prescaler counts from 0 to DIV-1 only while RUNNING and holds its value while STOPPED. When it reaches DIV-1 it wraps to 0 and generates a step.
- `clear` and `load` both reset the prescaler to 0.
- Priority on each edge: `reset` > `clear` > `load` > step. A step on the same cycle as `load` or `clear` is discarded, and `tick` does not pulse for it.
- Up step:
  - Digit 0 increments. A digit at 9 becomes 0 and carries into the next digit.
  - When all digits are 9, the value becomes all 0 and `wrap` pulses. The counter stays RUNNING.
- Loading: any `load_value` nibble greater than 9 is clamped to 9 per digit. The counter never holds a non-BCD value.
- `clear` and `load` do not change the state.

## Timing
- Reset values: `digits` = 0, `running` = 0, `tick` = 0, `wrap` = 0, prescaler = 0, state = STOPPED.
- `start` asserted at edge k:
  - `running` = 1 from edge k.
  - The first step occurs at edge k+DIV.
- On a step edge, `digits` takes its new value. `tick` and `wrap` are high for exactly the cycle that follows that edge.
- `clear` and `load` take effect at the next edge, with latency 1.
- A `reset` asserted mid-count returns all outputs to their reset values at the next edge. Any pending step is lost.

## Configuration
- `BCD_TIMER_DOWN_EN` defined:
  - The `down` port exists.
  - Down step: digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - A step taken while the value is all 0 leaves the value at 0, pulses `wrap`, and forces STOPPED. `running` drops on that same edge.
  - `down` is sampled on each step edge, so the direction may change mid-run.
- `BCD_TIMER_DOWN_EN` not defined: the counter is up-only, the `down` port is absent, and `wrap` means rollover only.

## Structure
- Package `bcd_timer_pkg` holds:
  - the state enum (`ST_STOPPED`, `ST_RUNNING`);
  - `BCD_MAX = 4'd9`;
  - a BCD clamp function.
- Sub-module `bcd_digit` is a single digit.
  - Inputs: `inc`, `dec`, `load`, `clear`, `d`.
  - Outputs: `q`, `carry`, `borrow`.
  - The top module instantiates `DIGITS` copies of it in a generate loop, chaining `carry` and `borrow`.
- The prescaler and state machine are in the top module.

## Test plan
- Reset behaviour. Stimulus: CLK_HZ=4, TICK_HZ=1; assert `reset`, then `start`. Response:
  - `digits` = 0 and `running` = 0 after reset.
  - Steps occur every 4 clocks.
  - After 12 steps, `digits` = 0x0012.
- Up rollover. Stimulus: `load` 0x9998, then run 2 steps. Response:
  - Step 1 gives 0x9999.
  - Step 2 gives 0x0000, with `wrap` pulsing for 1 cycle coincident with `tick`.
- Clamp and priority. Stimulus: `load` 0xA5F3 with `clear` high in the same cycle. Response: `digits` = 0.
  - Stimulus: `load` 0xA5F3 alone. Response: `digits` = 0x9593.
- Start/stop collision. Stimulus: `start` and `stop` asserted together in STOPPED. Response: `running` stays 0.
  - Stimulus: `start`, then `stop` at cycle 2. Response: `digits` unchanged and the prescaler held.
  - Stimulus: `start` again. Response: the step arrives after the remaining 2 clocks, not 4.
- Down expiry (`BCD_TIMER_DOWN_EN`). Stimulus: `load` 0x0100, `down` = 1, run. Response:
  - Steps give 0x0099, then 0x0098.
  - Stimulus: `load` 0x0001. Response:
    - Step 1 gives 0x0000.
    - Step 2 keeps 0x0000, pulses `wrap`, and drops `running` on the same edge.
- Mid-count reset. Stimulus: assert `reset` one cycle before a step. Response:
  - All outputs return to reset values.
  - No `tick` pulse occurs.
